// File: rtl/sdram_dev_model.sv
// Cycle-level SDRAM device responder: decodes controller commands, keeps
// per-bank open-row state and timing, stores data in a reduced array and
// returns read bursts after the programmed CAS latency. Protocol and timing
// violations are collected in sticky error flags.
module sdram_dev_model #(
  parameter int unsigned ROW_WIDTH    = 13,
  parameter int unsigned COL_WIDTH    = 9,
  parameter int unsigned MEM_ROW_BITS = 2,
  parameter int unsigned DELAY_RCD    = 1,
  parameter int unsigned DELAY_RP     = 1,
  parameter int unsigned DELAY_RC     = 3,
  parameter int unsigned DELAY_WR     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs,
  input  logic [2:0]           cmd,
  input  logic [1:0]           ba,
  input  logic [ROW_WIDTH-1:0] addr,
  input  logic [1:0]           dqm,
  input  logic                 wr_en,
  input  logic [15:0]          write_data,
  output logic [15:0]          read_data,
  output logic [ROW_WIDTH-1:0] mode_reg,
  output logic [15:0]          ref_count,
  output logic [5:0]           err
);

  localparam int unsigned MEM_AW    = 2 + MEM_ROW_BITS + COL_WIDTH;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned TW        = 4;

  localparam logic [TW-1:0] T_MAX = '1;
  localparam logic [TW-1:0] T_RCD = TW'(DELAY_RCD);
  localparam logic [TW-1:0] T_RP  = TW'(DELAY_RP);
  localparam logic [TW-1:0] T_RC  = TW'(DELAY_RC);
  localparam logic [TW-1:0] T_WR  = TW'(DELAY_WR);

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;

  typedef enum logic [1:0] {B_IDLE, B_ACTIVE, B_PRECHG} bank_state_t;

  // Per-bank state; only the stored (non-aliasing) row bits are kept.
  bank_state_t             bst       [4];
  logic [MEM_ROW_BITS-1:0] open_row  [4];
  logic [TW-1:0]           since_act [4];
  logic [TW-1:0]           rp_left   [4];
  logic [TW-1:0]           ap_left   [4];
  logic [TW-1:0]           since_ref;
  logic                    mode_valid;

  // Second beat of a 2-beat burst waiting for its slot.
  logic                    burst_pend;
  logic                    burst_wr;
  logic                    burst_ap;
  logic [1:0]              burst_ba;
  logic [COL_WIDTH-1:0]    burst_col;

  logic [15:0]             cas_pipe;
  logic [15:0]             mem [MEM_DEPTH];

  logic                    take;
  logic                    cmd_act, cmd_pre, cmd_wr, cmd_rd, cmd_mrs, cmd_ref;
  logic                    all_idle, any_prechg, bank_open;
  logic                    cl3, bl2, mode_good;
  logic                    rw_ok, act_ok, ref_ok, mrs_ok;
  logic                    beat_en, beat_wr, beat_last, beat_ap;
  logic [1:0]              beat_ba;
  logic [COL_WIDTH-1:0]    beat_col;
  logic [MEM_AW-1:0]       mem_addr;
  logic [15:0]             mem_q;
  logic                    rd_now, wr_now, ap_now;
  logic [3:0]              pre_go;
  logic [5:0]              err_set;

  // Command decode, legality, beat selection and violation detection.
  always_comb begin
    take    = !rst && cke && !cs;
    cmd_act = take && (cmd == C_ACT);
    cmd_pre = take && (cmd == C_PRE);
    cmd_wr  = take && (cmd == C_WR);
    cmd_rd  = take && (cmd == C_RD);
    cmd_mrs = take && (cmd == C_MRS);
    cmd_ref = take && (cmd == C_REF);

    all_idle   = 1'b1;
    any_prechg = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bst[b] != B_IDLE)   all_idle   = 1'b0;
      if (bst[b] == B_PRECHG) any_prechg = 1'b1;
    end

    cl3       = (mode_reg[6:4] == 3'd3);
    bl2       = mode_reg[0];
    mode_good = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:1] == 2'b00);
    bank_open = (bst[ba] == B_ACTIVE);

    rw_ok  = (cmd_rd || cmd_wr) && mode_valid && bank_open;
    act_ok = cmd_act && mode_valid && !bank_open;
    ref_ok = cmd_ref && mode_valid && all_idle;
    mrs_ok = cmd_mrs && all_idle && mode_good;

    // A new READ/WRITE takes the array slot and drops any pending beat.
    beat_en   = 1'b0;
    beat_wr   = 1'b0;
    beat_last = 1'b0;
    beat_ap   = 1'b0;
    beat_ba   = ba;
    beat_col  = addr[COL_WIDTH-1:0];
    if (rw_ok) begin
      beat_en   = 1'b1;
      beat_wr   = cmd_wr;
      beat_last = !bl2;
      beat_ap   = addr[10];
    end else if (burst_pend && !rst) begin
      beat_en   = 1'b1;
      beat_wr   = burst_wr;
      beat_last = 1'b1;
      beat_ap   = burst_ap;
      beat_ba   = burst_ba;
      beat_col  = burst_col;
    end

    mem_addr = {beat_ba, open_row[beat_ba], beat_col};
    mem_q    = mem[mem_addr];
    rd_now   = beat_en && !beat_wr;
    wr_now   = beat_en && beat_wr && cke && wr_en;
    ap_now   = beat_en && beat_last && beat_ap;

    // Banks that start precharging at the end of this cycle.
    pre_go = '0;
    for (int b = 0; b < 4; b++) begin
      pre_go[b] = (cmd_pre && (addr[10] || (ba == 2'(b))) && (bst[b] == B_ACTIVE)) ||
                  (ap_left[b] == TW'(1)) ||
                  (ap_now && (beat_ba == 2'(b)) && (!beat_wr || (T_WR == '0)));
    end

    err_set    = '0;
    err_set[0] = (cmd_rd || cmd_wr) && mode_valid && !bank_open;
    err_set[1] = cmd_act && mode_valid && bank_open;
    err_set[2] = rw_ok && (since_act[ba] <= T_RCD);
    err_set[3] = (act_ok && ((since_act[ba] < T_RC) || (bst[ba] == B_PRECHG) ||
                             (since_ref < T_RC))) ||
                 (cmd_ref && mode_valid && (any_prechg || (since_ref < T_RC)));
    err_set[4] = ((cmd_act || cmd_rd || cmd_wr || cmd_ref) && !mode_valid) ||
                 (cmd_mrs && all_idle && !mode_good);
    err_set[5] = (cmd_ref || cmd_mrs) && !all_idle;
  end

  // Bank FSMs, timers, mode/refresh state, burst tracking and read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        bst[b]       <= B_IDLE;
        open_row[b]  <= '0;
        since_act[b] <= T_MAX;
        rp_left[b]   <= '0;
        ap_left[b]   <= '0;
      end
      since_ref  <= T_MAX;
      mode_valid <= 1'b0;
      mode_reg   <= '0;
      ref_count  <= '0;
      err        <= '0;
      burst_pend <= 1'b0;
      burst_wr   <= 1'b0;
      burst_ap   <= 1'b0;
      burst_ba   <= '0;
      burst_col  <= '0;
      cas_pipe   <= '0;
      read_data  <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (since_act[b] != T_MAX) since_act[b] <= since_act[b] + TW'(1);
        if (ap_left[b] != '0)      ap_left[b]   <= ap_left[b] - TW'(1);
        if (bst[b] == B_PRECHG) begin
          if (rp_left[b] < TW'(2)) bst[b] <= B_IDLE;
          else                     rp_left[b] <= rp_left[b] - TW'(1);
        end
        // Write auto-precharge waits out write recovery after the last beat.
        if (ap_now && beat_wr && (beat_ba == 2'(b)) && (T_WR != '0)) ap_left[b] <= T_WR;
        if (cmd_pre && (addr[10] || (ba == 2'(b)))) ap_left[b] <= '0;
        if (pre_go[b]) begin
          bst[b]     <= (T_RP > TW'(1)) ? B_PRECHG : B_IDLE;
          rp_left[b] <= T_RP - TW'(1);
        end
        if (act_ok && (ba == 2'(b))) begin
          bst[b]       <= B_ACTIVE;
          open_row[b]  <= addr[MEM_ROW_BITS-1:0];
          since_act[b] <= TW'(1);
        end
      end

      if (since_ref != T_MAX) since_ref <= since_ref + TW'(1);
      if (ref_ok) begin
        since_ref <= TW'(1);
        ref_count <= ref_count + 16'd1;
      end
      if (mrs_ok) begin
        mode_reg   <= addr;
        mode_valid <= 1'b1;
      end
      err <= err | err_set;

      // An interrupted burst never reaches its last beat, so its auto-precharge is dropped.
      if (rw_ok) begin
        burst_pend <= bl2;
        burst_wr   <= cmd_wr;
        burst_ap   <= addr[10];
        burst_ba   <= ba;
        burst_col  <= {addr[COL_WIDTH-1:1], ~addr[0]};
      end else begin
        burst_pend <= 1'b0;
      end

      // CL2 returns the array word next cycle; CL3 adds one pipe stage.
      cas_pipe  <= (rd_now && cl3) ? mem_q : '0;
      read_data <= cl3 ? cas_pipe : (rd_now ? mem_q : '0);
    end
  end

  // Storage array with per-byte masking; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_now) begin
      if (!dqm[0]) mem[mem_addr][7:0]  <= write_data[7:0];
      if (!dqm[1]) mem[mem_addr][15:8] <= write_data[15:8];
    end
  end

endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed bench for sdram_dev_model: init, CL2/CL3 bursts, masking,
// column wrap, row aliasing, error flags, mid-burst reset and cke gating.
module tb_sdram_dev_model;

  localparam logic [2:0] MRS = 3'b000;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] NOP = 3'b111;

  logic        clk;
  logic        rst;
  logic        cke;
  logic        cs;
  logic [2:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [1:0]  dqm;
  logic        wr_en;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [12:0] mode_reg;
  logic [15:0] ref_count;
  logic [5:0]  err;

  int n_cmp;
  int n_bad;

  sdram_dev_model dut (
    .clk        (clk),
    .rst        (rst),
    .cke        (cke),
    .cs         (cs),
    .cmd        (cmd),
    .ba         (ba),
    .addr       (addr),
    .dqm        (dqm),
    .wr_en      (wr_en),
    .write_data (write_data),
    .read_data  (read_data),
    .mode_reg   (mode_reg),
    .ref_count  (ref_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then return to NOP after the sampling edge.
  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic we, input logic [15:0] wd, input logic [1:0] m);
    cs = 1'b0; cmd = c; ba = b; addr = a; wr_en = we; write_data = wd; dqm = m;
    @(negedge clk);
    cs = 1'b1; cmd = NOP; ba = 2'd0; addr = 13'd0; wr_en = 1'b0; write_data = 16'd0; dqm = 2'b00;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    drive(c, b, a, 1'b0, 16'h0000, 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; cke = 1'b1; cs = 1'b1; cmd = NOP; ba = 2'd0; addr = 13'd0;
    dqm = 2'b00; wr_en = 1'b0; write_data = 16'd0;
    idle(3);
    check_eq("rst_read_data", 32'(read_data), 32'h0);
    check_eq("rst_mode_reg",  32'(mode_reg),  32'h0);
    check_eq("rst_ref_count", 32'(ref_count), 32'h0);
    check_eq("rst_err",       32'(err),       32'h0);
    rst = 1'b0;

    // Init: precharge all, CL2/BL1, eight spaced refreshes.
    issue(PRE, 2'd0, 13'h400);
    issue(MRS, 2'd0, 13'h020);
    for (int i = 0; i < 8; i++) begin
      issue(REF, 2'd0, 13'h000);
      idle(2);
    end
    check_eq("init_mode_reg",  32'(mode_reg),  32'h020);
    check_eq("init_ref_count", 32'(ref_count), 32'd8);
    check_eq("init_err",       32'(err),       32'h0);

    // Bank 1 row 5: write 0xBEEF with auto-precharge, reopen, read back at CL2.
    issue(ACT, 2'd1, 13'd5);
    idle(1);
    drive(WR, 2'd1, 13'h404, 1'b1, 16'hBEEF, 2'b00);
    idle(2);
    issue(ACT, 2'd1, 13'd5);
    idle(1);
    issue(RD, 2'd1, 13'h404);
    check_eq("cl2_beat0", 32'(read_data), 32'hBEEF);
    idle(1);
    check_eq("cl2_after", 32'(read_data), 32'h0);
    check_eq("cl2_err",   32'(err),       32'h0);

    // CL3/BL2: clear two words, masked burst write, read with auto-precharge.
    issue(MRS, 2'd0, 13'h031);
    check_eq("mrs31_mode_reg", 32'(mode_reg), 32'h031);
    issue(ACT, 2'd2, 13'd6);
    idle(1);
    drive(WR,  2'd2, 13'h010, 1'b1, 16'h0000, 2'b00);
    drive(NOP, 2'd0, 13'h000, 1'b1, 16'h0000, 2'b00);
    drive(WR,  2'd2, 13'h010, 1'b1, 16'h1111, 2'b01);
    drive(NOP, 2'd0, 13'h000, 1'b1, 16'h2222, 2'b00);
    issue(RD, 2'd2, 13'h410);
    check_eq("cl3_gap",   32'(read_data), 32'h0);
    idle(1);
    check_eq("cl3_beat0", 32'(read_data), 32'h1100);
    idle(1);
    check_eq("cl3_beat1", 32'(read_data), 32'h2222);
    idle(1);
    check_eq("cl3_after", 32'(read_data), 32'h0);

    // Column wrap inside the 2-beat block: start at odd column.
    issue(ACT, 2'd2, 13'd6);
    idle(1);
    issue(RD, 2'd2, 13'h011);
    idle(1);
    check_eq("wrap_beat0", 32'(read_data), 32'h2222);
    idle(1);
    check_eq("wrap_beat1", 32'(read_data), 32'h1100);
    check_eq("wrap_err",   32'(err),       32'h0);

    // READ to idle bank 3 is ignored and flagged; ACT on an open bank flagged.
    issue(RD, 2'd3, 13'h000);
    idle(1);
    check_eq("idle_rd_data", 32'(read_data), 32'h0);
    check_eq("idle_rd_err",  32'(err),       32'h01);
    issue(ACT, 2'd0, 13'd0);
    idle(1);
    issue(ACT, 2'd0, 13'd1);
    check_eq("act_open_err", 32'(err), 32'h03);

    // tRCD violation, then REFRESH with banks open.
    issue(ACT, 2'd3, 13'd0);
    issue(RD,  2'd3, 13'h000);
    check_eq("rcd_err", 32'(err), 32'h07);
    idle(3);
    issue(REF, 2'd0, 13'h000);
    check_eq("ref_busy_err", 32'(err), 32'h27);

    // Bad CAS latency keeps the previous mode word.
    issue(PRE, 2'd0, 13'h400);
    issue(MRS, 2'd0, 13'h040);
    check_eq("bad_mrs_err",  32'(err),      32'h37);
    check_eq("bad_mrs_mode", 32'(mode_reg), 32'h031);

    // Reset in the middle of a CL3 burst.
    issue(ACT, 2'd2, 13'd6);
    idle(1);
    issue(RD, 2'd2, 13'h010);
    idle(1);
    check_eq("pre_rst_beat0", 32'(read_data), 32'h1100);
    rst = 1'b1;
    idle(1);
    check_eq("mid_rst_data", 32'(read_data), 32'h0);
    check_eq("mid_rst_err",  32'(err),       32'h0);
    check_eq("mid_rst_mode", 32'(mode_reg),  32'h0);
    check_eq("mid_rst_refs", 32'(ref_count), 32'h0);
    rst = 1'b0;

    // Re-init at CL2/BL1; stored data survives; row 1 aliases row 5.
    issue(PRE, 2'd0, 13'h400);
    issue(MRS, 2'd0, 13'h020);
    issue(ACT, 2'd2, 13'd6);
    idle(1);
    issue(RD, 2'd2, 13'h410);
    check_eq("kept_b2", 32'(read_data), 32'h1100);
    issue(ACT, 2'd1, 13'd1);
    idle(1);
    issue(RD, 2'd1, 13'h404);
    check_eq("alias_b1", 32'(read_data), 32'hBEEF);

    // cke low hides the command; cke high lets the refresh through.
    cke = 1'b0;
    issue(REF, 2'd0, 13'h000);
    check_eq("cke0_refs", 32'(ref_count), 32'h0);
    cke = 1'b1;
    issue(REF, 2'd0, 13'h000);
    check_eq("cke1_refs", 32'(ref_count), 32'h1);
    check_eq("final_err", 32'(err),       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
